// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - frame blitter: background, tile sprites, optional cursor (SPRITE_BLITTER_CURSOR_EN)
module sprite_blitter #(
    parameter int  SCREEN_W  = 320,
    parameter int  SCREEN_H  = 240,
    parameter int  TILE_W    = 17,
    parameter int  TILE_H    = 17,
    parameter int  NUM_TILES = 4,
    parameter int  COLOR_W   = 3,
    parameter int  CURSOR_SZ = 4,
    localparam int XW        = $clog2(SCREEN_W),
    localparam int YW        = $clog2(SCREEN_H),
    localparam int TIW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic               clk,
    input  logic               iReset,
    input  logic               V_SYNC,
    input  logic [XW-1:0]      iMouseX,
    input  logic [YW-1:0]      iMouseY,
    output logic [TIW-1:0]     oTileIdx,
    input  logic               iTileValid,
    input  logic [XW-1:0]      iTileX,
    input  logic [YW-1:0]      iTileY,
    input  logic [7:0]         iTileGlyph,
    output logic               oRomSel,
    output logic [19:0]        oRomAddr,
    input  logic [COLOR_W-1:0] iRomData,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [COLOR_W-1:0] color,
    output logic               writeEn,
    output logic               oBusy,
    output logic               oMissed
);

    typedef enum logic [2:0] {S_IDLE, S_BACK, S_TFETCH, S_TDRAW, S_CURSOR} state_t;

    state_t         state_q;
    logic [XW-1:0]  cx_q;
    logic [YW-1:0]  cy_q;
    logic [TIW-1:0] slot_q;
    logic [XW-1:0]  tile_x_q;
    logic [YW-1:0]  tile_y_q;
    logic [7:0]     glyph_q;
    logic           vs_prev_q;
    logic           busy_q;
    logic           missed_q;
    logic           wr_q;
    logic           rom_src_q;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;

    logic           vs_fall;
    logic           issue;
    logic           on_screen;
    logic [XW:0]    px;
    logic [YW:0]    py;
    logic [XW:0]    cur_x0;
    logic [YW:0]    cur_y0;

    assign vs_fall = vs_prev_q & ~V_SYNC;

`ifdef SPRITE_BLITTER_CURSOR_EN
    localparam state_t AFTER_TILES = S_CURSOR;

    logic [XW-1:0] mouse_x_q;
    logic [YW-1:0] mouse_y_q;

    // Cursor origin centred on the mouse; negative results wrap high and are clipped
    assign cur_x0 = {1'b0, mouse_x_q} - (XW+1)'(CURSOR_SZ / 2);
    assign cur_y0 = {1'b0, mouse_y_q} - (YW+1)'(CURSOR_SZ / 2);

    // Capture the mouse once per frame so the cursor cannot tear mid-draw
    always_ff @(posedge clk) begin
        if (iReset) begin
            mouse_x_q <= '0;
            mouse_y_q <= '0;
        end else if (state_q == S_IDLE && vs_fall) begin
            mouse_x_q <= iMouseX;
            mouse_y_q <= iMouseY;
        end
    end
`else
    localparam state_t AFTER_TILES = S_IDLE;

    logic unused_mouse;
    assign unused_mouse = ^{iMouseX, iMouseY};
    assign cur_x0       = '0;
    assign cur_y0       = '0;
`endif

    // Screen position of the pixel issued this cycle, one bit wide of the screen range
    always_comb begin
        px    = '0;
        py    = '0;
        issue = 1'b0;
        case (state_q)
            S_BACK: begin
                px    = {1'b0, cx_q};
                py    = {1'b0, cy_q};
                issue = 1'b1;
            end
            S_TDRAW: begin
                px    = {1'b0, tile_x_q} + {1'b0, cx_q};
                py    = {1'b0, tile_y_q} + {1'b0, cy_q};
                issue = 1'b1;
            end
            S_CURSOR: begin
                px    = cur_x0 + {1'b0, cx_q};
                py    = cur_y0 + {1'b0, cy_q};
                issue = 1'b1;
            end
            default: ;
        endcase
    end

    assign on_screen = (px < (XW+1)'(SCREEN_W)) && (py < (YW+1)'(SCREEN_H));

    // ROM address for the current pixel: background raster or glyph sub-image
    always_comb begin
        oRomAddr = '0;
        if (state_q == S_BACK) begin
            oRomAddr = 20'(cy_q) * 20'(SCREEN_W) + 20'(cx_q);
        end else if (state_q == S_TDRAW) begin
            oRomAddr = 20'(glyph_q) * 20'(TILE_W * TILE_H) + 20'(cy_q) * 20'(TILE_W) + 20'(cx_q);
        end
    end

    // Frame sequencer plus the single write-pipeline stage
    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            slot_q    <= '0;
            tile_x_q  <= '0;
            tile_y_q  <= '0;
            glyph_q   <= '0;
            vs_prev_q <= 1'b0;
            busy_q    <= 1'b0;
            missed_q  <= 1'b0;
            wr_q      <= 1'b0;
            rom_src_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            vs_prev_q <= V_SYNC;
            missed_q  <= vs_fall && (state_q != S_IDLE);
            wr_q      <= issue && on_screen;
            rom_src_q <= (state_q != S_CURSOR);
            x_q       <= px[XW-1:0];
            y_q       <= py[YW-1:0];
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    cx_q   <= '0;
                    cy_q   <= '0;
                    slot_q <= '0;
                    if (vs_fall) begin
                        state_q <= S_BACK;
                        busy_q  <= 1'b1;
                    end
                end
                S_BACK: begin
                    if (cx_q == XW'(SCREEN_W - 1)) begin
                        cx_q <= '0;
                        if (cy_q == YW'(SCREEN_H - 1)) begin
                            cy_q    <= '0;
                            slot_q  <= '0;
                            state_q <= S_TFETCH;
                        end else begin
                            cy_q <= cy_q + YW'(1);
                        end
                    end else begin
                        cx_q <= cx_q + XW'(1);
                    end
                end
                S_TFETCH: begin
                    cx_q <= '0;
                    cy_q <= '0;
                    if (iTileValid) begin
                        tile_x_q <= iTileX;
                        tile_y_q <= iTileY;
                        glyph_q  <= iTileGlyph;
                        state_q  <= S_TDRAW;
                    end else if (slot_q == TIW'(NUM_TILES - 1)) begin
                        state_q <= AFTER_TILES;
                    end else begin
                        slot_q <= slot_q + TIW'(1);
                    end
                end
                S_TDRAW: begin
                    if (cx_q == XW'(TILE_W - 1)) begin
                        cx_q <= '0;
                        if (cy_q == YW'(TILE_H - 1)) begin
                            cy_q <= '0;
                            if (slot_q == TIW'(NUM_TILES - 1)) begin
                                state_q <= AFTER_TILES;
                            end else begin
                                slot_q  <= slot_q + TIW'(1);
                                state_q <= S_TFETCH;
                            end
                        end else begin
                            cy_q <= cy_q + YW'(1);
                        end
                    end else begin
                        cx_q <= cx_q + XW'(1);
                    end
                end
                S_CURSOR: begin
                    if (cx_q == XW'(CURSOR_SZ - 1)) begin
                        cx_q <= '0;
                        if (cy_q == YW'(CURSOR_SZ - 1)) begin
                            cy_q    <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cy_q <= cy_q + YW'(1);
                        end
                    end else begin
                        cx_q <= cx_q + XW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oTileIdx = slot_q;
    assign oRomSel  = (state_q == S_TDRAW);
    assign x        = x_q;
    assign y        = y_q;
    assign writeEn  = wr_q;
    assign color    = (wr_q && rom_src_q) ? iRomData : '0;
    assign oBusy    = busy_q;
    assign oMissed  = missed_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter on a reduced 40x30 screen
module tb_sprite_blitter;

    localparam int W   = 40;
    localparam int H   = 30;
    localparam int TW  = 17;
    localparam int TH  = 17;
    localparam int NT  = 4;
    localparam int CW  = 3;
    localparam int CS  = 4;
    localparam int XW  = $clog2(W);
    localparam int YW  = $clog2(H);
    localparam int TIW = 2;

`ifdef SPRITE_BLITTER_CURSOR_EN
    localparam int CUR_CYC = 16;
    localparam int CUR_WR0 = 4;
    localparam int CUR_WR1 = 9;
`else
    localparam int CUR_CYC = 0;
    localparam int CUR_WR0 = 0;
    localparam int CUR_WR1 = 0;
`endif

    localparam int LEN_A = 1200 + 4 + 1 + CUR_CYC;
    localparam int LEN_B = 1200 + 4 + 289 + 1 + CUR_CYC;
    localparam int WR_A  = 1200 + CUR_WR0;
    localparam int WR_B  = 1200 + 289 + CUR_WR0;
    localparam int WR_C  = 1200 + 100 + CUR_WR1;

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    logic            clk = 1'b0;
    logic            iReset;
    logic            V_SYNC;
    logic [XW-1:0]   iMouseX;
    logic [YW-1:0]   iMouseY;
    logic [TIW-1:0]  oTileIdx;
    logic            iTileValid;
    logic [XW-1:0]   iTileX;
    logic [YW-1:0]   iTileY;
    logic [7:0]      iTileGlyph;
    logic            oRomSel;
    logic [19:0]     oRomAddr;
    logic [CW-1:0]   iRomData;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   color;
    logic            writeEn;
    logic            oBusy;
    logic            oMissed;

    logic            t_v [NT];
    logic [XW-1:0]   t_x [NT];
    logic [YW-1:0]   t_y [NT];
    logic [7:0]      t_g [NT];
    logic [CW-1:0]   rom_q;

    px_t             exp_q[$];
    int              checks = 0;
    int              failures = 0;
    int              wr_cnt = 0;
    int              miss_cnt = 0;
    logic            missed_prev = 1'b0;
    int              sel_seen;
    int              first_sel_addr;
    int              first_sel_idx;

    always #5 clk = ~clk;

    sprite_blitter #(
        .SCREEN_W(W), .SCREEN_H(H), .TILE_W(TW), .TILE_H(TH),
        .NUM_TILES(NT), .COLOR_W(CW), .CURSOR_SZ(CS)
    ) dut (
        .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC),
        .iMouseX(iMouseX), .iMouseY(iMouseY),
        .oTileIdx(oTileIdx), .iTileValid(iTileValid), .iTileX(iTileX),
        .iTileY(iTileY), .iTileGlyph(iTileGlyph),
        .oRomSel(oRomSel), .oRomAddr(oRomAddr), .iRomData(iRomData),
        .x(x), .y(y), .color(color), .writeEn(writeEn),
        .oBusy(oBusy), .oMissed(oMissed)
    );

    assign iTileValid = t_v[oTileIdx];
    assign iTileX     = t_x[oTileIdx];
    assign iTileY     = t_y[oTileIdx];
    assign iTileGlyph = t_g[oTileIdx];

    // ROM whose content is the low address bits, one cycle of latency
    always @(posedge clk) rom_q <= oRomAddr[CW-1:0];
    assign iRomData = rom_q;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tiles();
        for (int s = 0; s < NT; s++) begin
            t_v[s] = 1'b0;
            t_x[s] = '0;
            t_y[s] = '0;
            t_g[s] = '0;
        end
    endtask

    // Expected write list: raster background, then each valid tile, then the cursor
    task automatic build_model(output int elen, output int ewr);
        px_t e;
        int  px;
        int  py;
        exp_q.delete();
        elen = W * H + NT + 1;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                e.x = xx;
                e.y = yy;
                e.c = (yy * W + xx) % (1 << CW);
                exp_q.push_back(e);
            end
        end
        for (int s = 0; s < NT; s++) begin
            if (t_v[s]) begin
                elen += TW * TH;
                for (int ty = 0; ty < TH; ty++) begin
                    for (int tx = 0; tx < TW; tx++) begin
                        px = int'(t_x[s]) + tx;
                        py = int'(t_y[s]) + ty;
                        if (px < W && py < H) begin
                            e.x = px;
                            e.y = py;
                            e.c = (int'(t_g[s]) * TW * TH + ty * TW + tx) % (1 << CW);
                            exp_q.push_back(e);
                        end
                    end
                end
            end
        end
`ifdef SPRITE_BLITTER_CURSOR_EN
        elen += CS * CS;
        for (int cy = 0; cy < CS; cy++) begin
            for (int cx = 0; cx < CS; cx++) begin
                px = int'(iMouseX) - CS / 2 + cx;
                py = int'(iMouseY) - CS / 2 + cy;
                if (px >= 0 && px < W && py >= 0 && py < H) begin
                    e.x = px;
                    e.y = py;
                    e.c = 0;
                    exp_q.push_back(e);
                end
            end
        end
`endif
        ewr = exp_q.size();
    endtask

    // Issue a V_SYNC falling edge and follow the frame until oBusy drops
    task automatic run_frame(input int miss_at, output int blen);
        int guard;
        wr_cnt   = 0;
        miss_cnt = 0;
        sel_seen = 0;
        first_sel_addr = -1;
        first_sel_idx  = -1;
        V_SYNC = 1'b1;
        step();
        V_SYNC = 1'b0;
        guard = 0;
        while (!oBusy && guard < 5) begin
            step();
            guard++;
        end
        check_eq("busy_rise", int'(oBusy), 1);
        check_eq("first_back_addr", int'(oRomAddr), 0);
        blen = 0;
        while (oBusy && blen < 20000) begin
            if (oRomSel && sel_seen == 0) begin
                sel_seen       = 1;
                first_sel_addr = int'(oRomAddr);
                first_sel_idx  = int'(oTileIdx);
            end
            if (blen == miss_at)     V_SYNC = 1'b1;
            if (blen == miss_at + 1) V_SYNC = 1'b0;
            blen++;
            step();
        end
        check_eq("busy_fall_in_budget", int'(oBusy), 0);
        check_eq("queue_drained", exp_q.size(), 0);
    endtask

    // Every cycle: writes must match the model in order; idle cycles carry color 0
    always @(negedge clk) begin
        px_t e;
        if (writeEn) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected actual=(%0d,%0d,c%0d) expected=no write", x, y, color);
            end else begin
                e = exp_q.pop_front();
                if (int'(x) != e.x || int'(y) != e.y || int'(color) != e.c) begin
                    failures++;
                    $display("FAIL write_pixel actual=(%0d,%0d,c%0d) expected=(%0d,%0d,c%0d)",
                             x, y, color, e.x, e.y, e.c);
                end
            end
        end else begin
            checks++;
            if (color != '0) begin
                failures++;
                $display("FAIL idle_color actual=%0d expected=0", color);
            end
        end
        if (oMissed) begin
            miss_cnt++;
            checks++;
            if (missed_prev) begin
                failures++;
                $display("FAIL missed_pulse_width actual=2+ cycles expected=1");
            end
        end
        missed_prev = oMissed;
    end

    initial begin
        int blen;
        int elen;
        int ewr;

        iReset  = 1'b1;
        V_SYNC  = 1'b1;
        iMouseX = '0;
        iMouseY = '0;
        clear_tiles();
        repeat (3) step();
        check_eq("rst_writeEn", int'(writeEn), 0);
        check_eq("rst_busy", int'(oBusy), 0);
        check_eq("rst_missed", int'(oMissed), 0);
        check_eq("rst_romaddr", int'(oRomAddr), 0);
        check_eq("rst_romsel", int'(oRomSel), 0);
        check_eq("rst_tileidx", int'(oTileIdx), 0);
        check_eq("rst_xy", int'(x) + int'(y), 0);
        check_eq("rst_color", int'(color), 0);

        // V_SYNC low right as reset drops: no remembered high level, no frame
        iReset = 1'b0;
        V_SYNC = 1'b0;
        repeat (4) step();
        check_eq("no_start_after_reset", int'(oBusy), 0);

        // Frame A: background only
        build_model(elen, ewr);
        check_eq("A_model_writes", ewr, WR_A);
        run_frame(-1, blen);
        check_eq("A_busy_len_model", blen, elen);
        check_eq("A_busy_len", blen, LEN_A);
        check_eq("A_writes", wr_cnt, WR_A);
        check_eq("A_missed", miss_cnt, 0);

        // Frame B: slot 2 at (12,8), glyph 3
        t_v[2] = 1'b1;
        t_x[2] = XW'(12);
        t_y[2] = YW'(8);
        t_g[2] = 8'd3;
        build_model(elen, ewr);
        check_eq("B_model_writes", ewr, WR_B);
        run_frame(-1, blen);
        check_eq("B_busy_len", blen, LEN_B);
        check_eq("B_writes", wr_cnt, WR_B);
        check_eq("B_glyph_seen", sel_seen, 1);
        check_eq("B_glyph_first_addr", first_sel_addr, 867);
        check_eq("B_glyph_slot", first_sel_idx, 2);

        // Frame C: tile hanging off the corner, mouse near origin, a dropped request
        clear_tiles();
        t_v[0]  = 1'b1;
        t_x[0]  = XW'(30);
        t_y[0]  = YW'(20);
        t_g[0]  = 8'd1;
        iMouseX = XW'(1);
        iMouseY = YW'(1);
        build_model(elen, ewr);
        check_eq("C_model_writes", ewr, WR_C);
        run_frame(100, blen);
        check_eq("C_busy_len", blen, LEN_B);
        check_eq("C_writes", wr_cnt, WR_C);
        check_eq("C_missed", miss_cnt, 1);

        // Frame D: reset at background pixel 500 aborts the frame
        clear_tiles();
        iMouseX = '0;
        iMouseY = '0;
        build_model(elen, ewr);
        wr_cnt = 0;
        V_SYNC = 1'b1;
        step();
        V_SYNC = 1'b0;
        step();
        check_eq("D_busy_rise", int'(oBusy), 1);
        repeat (500) step();
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        exp_q.delete();
        check_eq("D_writeEn_after_rst", int'(writeEn), 0);
        check_eq("D_busy_after_rst", int'(oBusy), 0);
        repeat (20) step();
        check_eq("D_writes_before_abort", wr_cnt, 500);
        check_eq("D_still_idle", int'(oBusy), 0);

        // Frame E: restart after the abort begins again from address 0
        build_model(elen, ewr);
        run_frame(-1, blen);
        check_eq("E_busy_len", blen, LEN_A);
        check_eq("E_writes", wr_cnt, WR_A);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
